alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_mc.sv | 168 ++++++++++++++++
 tb/tb_alu_mc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops, plus shift-add MULU and
// restoring DIVU that iterate one bit per clock behind a busy/done handshake.
module alu_mc #(
   parameter int data_size = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [2:0]           ALUcontrol,
   input  logic [data_size-1:0] SrcA,
   input  logic [data_size-1:0] SrcB,
   output logic [data_size-1:0] ALUResult,
   output logic [data_size-1:0] HiResult,
   output logic                 Zero_flag,
   output logic                 Overflow,
   output logic                 busy,
   output logic                 done
);
   localparam int CW  = $clog2(data_size + 1);
   localparam int MSB = data_size - 1;

   typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
   typedef enum logic [2:0] {
      OP_AND  = 3'b000, OP_OR  = 3'b001, OP_ADD  = 3'b010, OP_DIVU = 3'b011,
      OP_SUB  = 3'b100, OP_MULU = 3'b101, OP_SLTU = 3'b110, OP_SLT  = 3'b111
   } op_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   // acc: running high word (MUL) or partial remainder (DIV)
   // wrk: multiplier shifting into product low word (MUL) or dividend shifting into quotient (DIV)
   logic [data_size-1:0] acc_q, acc_d, wrk_q, wrk_d, opb_q, opb_d;
   logic [data_size-1:0] res_lo_q, res_lo_d, res_hi_q, res_hi_d;
   logic                 ovf_q, ovf_d, done_q, done_d;

   logic [data_size:0]   mul_sum, div_shift, div_diff;
   logic [data_size-1:0] add_res, sub_res, mul_hi_n, mul_lo_n, div_rem_n, div_quo_n;
   logic                 last;
   op_e                  op;

   assign op   = op_e'(ALUcontrol);
   assign last = (cnt_q == CW'(data_size - 1));

   always_comb begin
      add_res   = SrcA + SrcB;
      sub_res   = SrcA - SrcB;
      mul_sum   = {1'b0, acc_q} + (wrk_q[0] ? {1'b0, opb_q} : '0);
      mul_hi_n  = mul_sum[data_size:1];
      mul_lo_n  = {mul_sum[0], wrk_q[MSB:1]};
      // remainder stays below the divisor, so the top bit of div_diff is a clean borrow
      div_shift = {acc_q, wrk_q[MSB]};
      div_diff  = div_shift - {1'b0, opb_q};
      div_rem_n = div_diff[data_size] ? div_shift[MSB:0] : div_diff[MSB:0];
      div_quo_n = {wrk_q[MSB-1:0], ~div_diff[data_size]};
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      wrk_d    = wrk_q;
      opb_d    = opb_q;
      res_lo_d = res_lo_q;
      res_hi_d = res_hi_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               done_d   = 1'b1;
               res_hi_d = '0;
               ovf_d    = 1'b0;
               case (op)
                  OP_AND:  res_lo_d = SrcA & SrcB;
                  OP_OR:   res_lo_d = SrcA | SrcB;
                  OP_ADD: begin
                     res_lo_d = add_res;
                     ovf_d    = (SrcA[MSB] == SrcB[MSB]) && (add_res[MSB] != SrcA[MSB]);
                  end
                  OP_SUB: begin
                     res_lo_d = sub_res;
                     ovf_d    = (SrcA[MSB] != SrcB[MSB]) && (sub_res[MSB] != SrcA[MSB]);
                  end
                  OP_SLTU: res_lo_d = {{(data_size-1){1'b0}}, SrcA < SrcB};
                  OP_SLT:  res_lo_d = {{(data_size-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
                  OP_MULU, OP_DIVU: begin
                     if (op == OP_DIVU && SrcB == '0) begin
                        res_lo_d = '1;
                        res_hi_d = SrcA;
                        ovf_d    = 1'b1;
                     end else begin
                        // results hold their previous values until the iteration completes
                        done_d   = 1'b0;
                        res_lo_d = res_lo_q;
                        res_hi_d = res_hi_q;
                        ovf_d    = ovf_q;
                        state_d  = (op == OP_MULU) ? MUL : DIV;
                        cnt_d    = '0;
                        acc_d    = '0;
                        wrk_d    = SrcA;
                        opb_d    = SrcB;
                     end
                  end
               endcase
            end
         end
         MUL: begin
            acc_d = mul_hi_n;
            wrk_d = mul_lo_n;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d  = IDLE;
               cnt_d    = '0;
               res_lo_d = mul_lo_n;
               res_hi_d = mul_hi_n;
               ovf_d    = |mul_hi_n;
               done_d   = 1'b1;
            end
         end
         DIV: begin
            acc_d = div_rem_n;
            wrk_d = div_quo_n;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
               state_d  = IDLE;
               cnt_d    = '0;
               res_lo_d = div_quo_n;
               res_hi_d = div_rem_n;
               ovf_d    = 1'b0;
               done_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         wrk_q    <= '0;
         opb_q    <= '0;
         res_lo_q <= '0;
         res_hi_q <= '0;
         ovf_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         wrk_q    <= wrk_d;
         opb_q    <= opb_d;
         res_lo_q <= res_lo_d;
         res_hi_q <= res_hi_d;
         ovf_q    <= ovf_d;
         done_q   <= done_d;
      end
   end

   assign ALUResult = res_lo_q;
   assign HiResult  = res_hi_q;
   assign Overflow  = ovf_q;
   assign done      = done_q;
   assign busy      = (state_q != IDLE);
   assign Zero_flag = (res_lo_q == '0);

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed vectors, back-to-back, reset abort and
// randomized ops on a 32-bit and an 8-bit instance against an arithmetic model.
module tb_alu_mc;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        st32 = 1'b0, st8 = 1'b0;
   logic [2:0]  op32 = '0, op8 = '0;
   logic [31:0] a32 = '0, b32 = '0, lo32, hi32;
   logic [7:0]  a8 = '0, b8 = '0, lo8, hi8;
   logic        z32, ov32, bz32, dn32, z8, ov8, bz8, dn8;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   alu_mc #(.data_size(32)) dut32 (
      .clk(clk), .rst(rst), .start(st32), .ALUcontrol(op32), .SrcA(a32), .SrcB(b32),
      .ALUResult(lo32), .HiResult(hi32), .Zero_flag(z32), .Overflow(ov32),
      .busy(bz32), .done(dn32));

   alu_mc #(.data_size(8)) dut8 (
      .clk(clk), .rst(rst), .start(st8), .ALUcontrol(op8), .SrcA(a8), .SrcB(b8),
      .ALUResult(lo8), .HiResult(hi8), .Zero_flag(z8), .Overflow(ov8),
      .busy(bz8), .done(dn8));

   // Reference: plain arithmetic on w-bit values; lat = edges from acceptance to completion
   function automatic void model(input int w, input logic [2:0] op, input logic [63:0] ai,
                                 input logic [63:0] bi, output logic [63:0] lo,
                                 output logic [63:0] hi, output logic ov, output int lat);
      logic [63:0] m, a, b, sgn, p;
      longint      sa, sb;
      m   = (64'd1 << w) - 64'd1;
      sgn = 64'd1 << (w - 1);
      a   = ai & m;
      b   = bi & m;
      sa  = ((a & sgn) != 0) ? longint'(a) - longint'(64'd1 << w) : longint'(a);
      sb  = ((b & sgn) != 0) ? longint'(b) - longint'(64'd1 << w) : longint'(b);
      hi  = '0; ov = 1'b0; lat = 0; lo = '0;
      case (op)
         3'd0: lo = a & b;
         3'd1: lo = a | b;
         3'd2: begin
            lo = (a + b) & m;
            ov = ((a & sgn) == (b & sgn)) && ((lo & sgn) != (a & sgn));
         end
         3'd4: begin
            lo = (a - b) & m;
            ov = ((a & sgn) != (b & sgn)) && ((lo & sgn) != (a & sgn));
         end
         3'd6: lo = (a < b) ? 64'd1 : 64'd0;
         3'd7: lo = (sa < sb) ? 64'd1 : 64'd0;
         3'd5: begin
            p = a * b;
            lo = p & m; hi = (p >> w) & m; ov = (hi != 0); lat = w;
         end
         default: begin
            if (b == 0) begin lo = m; hi = a; ov = 1'b1; end
            else begin lo = a / b; hi = a % b; lat = w; end
         end
      endcase
   endfunction

   task automatic drive(input bit s8, input logic st, input logic [2:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (s8) begin st8 = st; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
      else begin st32 = st; op32 = op; a32 = a[31:0]; b32 = b[31:0]; end
   endtask

   task automatic sample(input bit s8, output logic [63:0] lo, output logic [63:0] hi,
                         output logic ov, output logic z, output logic bz, output logic dn);
      if (s8) begin lo = {56'd0, lo8}; hi = {56'd0, hi8}; ov = ov8; z = z8; bz = bz8; dn = dn8; end
      else begin lo = {32'd0, lo32}; hi = {32'd0, hi32}; ov = ov32; z = z32; bz = bz32; dn = dn32; end
   endtask

   // Stimulus only: starts one op, scrambles operands, pokes start while busy, waits for done
   task automatic issue(input bit s8, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, output logic [63:0] lo, output logic [63:0] hi,
                        output logic ov, output logic z, output int lat, output logic bz_first,
                        output logic bz_done, output logic dn_after, output logic held);
      logic [63:0] lo2, hi2;
      logic        ov2, z2, bz2, dn;
      @(negedge clk);
      drive(s8, 1'b1, op, a, b);
      @(posedge clk); #1;
      drive(s8, 1'b0, 3'($urandom_range(0, 7)), {$urandom, $urandom}, {$urandom, $urandom});
      sample(s8, lo, hi, ov, z, bz_first, dn);
      bz_done = bz_first;
      lat = 0;
      while (dn !== 1'b1 && lat < 300) begin
         drive(s8, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
               {$urandom, $urandom}, {$urandom, $urandom});
         @(posedge clk); #1;
         lat++;
         sample(s8, lo, hi, ov, z, bz_done, dn);
      end
      drive(s8, 1'b0, 3'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      sample(s8, lo2, hi2, ov2, z2, bz2, dn_after);
      held = (lo2 === lo) && (hi2 === hi) && (ov2 === ov);
   endtask

   task automatic test_reset;
      logic [63:0] lo, hi;
      logic        ov, z, bz, dn;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sample(s[0], lo, hi, ov, z, bz, dn);
         checks += 6;
         if (lo !== 0) begin errors++; $display("FAIL reset_lo[%0d] got=%h exp=0", s, lo); end
         if (hi !== 0) begin errors++; $display("FAIL reset_hi[%0d] got=%h exp=0", s, hi); end
         if (ov !== 0) begin errors++; $display("FAIL reset_ov[%0d] got=%b exp=0", s, ov); end
         if (z !== 1)  begin errors++; $display("FAIL reset_zero[%0d] got=%b exp=1", s, z); end
         if (bz !== 0) begin errors++; $display("FAIL reset_busy[%0d] got=%b exp=0", s, bz); end
         if (dn !== 0) begin errors++; $display("FAIL reset_done[%0d] got=%b exp=0", s, dn); end
      end
      // first edge with rst low must already accept a start
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b1, 3'd2, 64'd2, 64'd3);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      checks += 2;
      if (dn32 !== 1'b1) begin errors++; $display("FAIL first_start_done got=%b exp=1", dn32); end
      if (lo32 !== 32'd5) begin errors++; $display("FAIL first_start_lo got=%h exp=5", lo32); end
   endtask

   task automatic test_directed;
      logic [63:0] lo, hi, elo, ehi;
      logic        ov, z, eov, bzf, bzd, dna, held;
      int          lat, elat;
      logic [64+64+3:0] vec [15];
      vec = '{{1'b0, 3'd2, 64'h7FFFFFFF, 64'h1}, {1'b0, 3'd5, 64'hFFFFFFFF, 64'hFFFFFFFF},
              {1'b0, 3'd3, 64'd100, 64'd7},      {1'b0, 3'd3, 64'd9, 64'd0},
              {1'b0, 3'd4, 64'h80000000, 64'h1}, {1'b0, 3'd0, 64'hF0F0F0F0, 64'hFF00FF00},
              {1'b0, 3'd1, 64'h0F0F0000, 64'h000000F0}, {1'b0, 3'd6, 64'hFFFFFFFF, 64'h1},
              {1'b0, 3'd7, 64'hFFFFFFFF, 64'h1}, {1'b0, 3'd3, 64'hFFFFFFFF, 64'h1},
              {1'b0, 3'd5, 64'h0, 64'h12345},    {1'b0, 3'd4, 64'd5, 64'd5},
              {1'b1, 3'd5, 64'hFF, 64'hFF},      {1'b1, 3'd3, 64'hFF, 64'h10},
              {1'b1, 3'd2, 64'h7F, 64'h1}};
      for (int i = 0; i < 15; i++) begin
         bit s8;
         logic [2:0] op;
         logic [63:0] a, b;
         {s8, op, a, b} = vec[i];
         model(s8 ? 8 : 32, op, a, b, elo, ehi, eov, elat);
         issue(s8, op, a, b, lo, hi, ov, z, lat, bzf, bzd, dna, held);
         checks += 9;
         if (lat !== elat) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, elat); end
         if (lo !== elo) begin errors++; $display("FAIL dir%0d_lo got=%h exp=%h", i, lo, elo); end
         if (hi !== ehi) begin errors++; $display("FAIL dir%0d_hi got=%h exp=%h", i, hi, ehi); end
         if (ov !== eov) begin errors++; $display("FAIL dir%0d_ov got=%b exp=%b", i, ov, eov); end
         if (z !== (elo == 0)) begin errors++; $display("FAIL dir%0d_zero got=%b exp=%b", i, z, elo == 0); end
         if (bzf !== (elat > 0)) begin errors++; $display("FAIL dir%0d_busy got=%b exp=%b", i, bzf, elat > 0); end
         if (bzd !== 1'b0) begin errors++; $display("FAIL dir%0d_busy_at_done got=%b exp=0", i, bzd); end
         if (dna !== 1'b0) begin errors++; $display("FAIL dir%0d_done_width got=%b exp=0", i, dna); end
         if (held !== 1'b1) begin errors++; $display("FAIL dir%0d_hold got=%b exp=1", i, held); end
      end
   endtask

   task automatic test_back_to_back;
      logic [63:0] elo, ehi;
      logic        eov;
      int          elat;
      logic [2:0]  ops [3] = '{3'd4, 3'd7, 3'd6};
      logic [31:0] as  [3] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [31:0] bs  [3] = '{32'd5, 32'd1, 32'd1};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, ops[i], {32'd0, as[i]}, {32'd0, bs[i]});
         @(posedge clk); #1;
         model(32, ops[i], {32'd0, as[i]}, {32'd0, bs[i]}, elo, ehi, eov, elat);
         checks += 3;
         if (dn32 !== 1'b1) begin errors++; $display("FAIL b2b%0d_done got=%b exp=1", i, dn32); end
         if (lo32 !== elo[31:0]) begin errors++; $display("FAIL b2b%0d_lo got=%h exp=%h", i, lo32, elo[31:0]); end
         if (z32 !== (elo == 0)) begin errors++; $display("FAIL b2b%0d_zero got=%b exp=%b", i, z32, elo == 0); end
      end
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      @(posedge clk); #1;
      checks++;
      if (dn32 !== 1'b0) begin errors++; $display("FAIL b2b_done_end got=%b exp=0", dn32); end
   endtask

   task automatic test_reset_abort;
      logic [63:0] lo, hi;
      logic        ov, z, bzf, bzd, dna, held, saw_done;
      int          lat;
      issue(1'b0, 3'd3, 64'd9, 64'd0, lo, hi, ov, z, lat, bzf, bzd, dna, held);
      @(negedge clk);
      drive(1'b0, 1'b1, 3'd5, 64'hFFFFFFFF, 64'hFFFFFFFF);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      repeat (9) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b1, 3'd2, 64'd1, 64'd1);
      @(posedge clk); #1;
      checks += 6;
      if (lo32 !== 0) begin errors++; $display("FAIL abort_lo got=%h exp=0", lo32); end
      if (hi32 !== 0) begin errors++; $display("FAIL abort_hi got=%h exp=0", hi32); end
      if (ov32 !== 0) begin errors++; $display("FAIL abort_ov got=%b exp=0", ov32); end
      if (z32 !== 1)  begin errors++; $display("FAIL abort_zero got=%b exp=1", z32); end
      if (bz32 !== 0) begin errors++; $display("FAIL abort_busy got=%b exp=0", bz32); end
      if (dn32 !== 0) begin errors++; $display("FAIL abort_done got=%b exp=0", dn32); end
      drive(1'b0, 1'b0, 3'd0, 64'd0, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      saw_done = 1'b0;
      repeat (40) begin
         @(posedge clk); #1;
         if (dn32 === 1'b1 || bz32 === 1'b1) saw_done = 1'b1;
      end
      checks++;
      if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got=%b exp=0", saw_done); end
      issue(1'b0, 3'd2, 64'd2, 64'd3, lo, hi, ov, z, lat, bzf, bzd, dna, held);
      checks += 2;
      if (lo !== 64'd5) begin errors++; $display("FAIL abort_then_add got=%h exp=5", lo); end
      if (lat !== 0) begin errors++; $display("FAIL abort_then_add_lat got=%0d exp=0", lat); end
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 4))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'($urandom_range(0, 15));
         3:       return 64'h80000000 | 64'h80;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic test_random;
      logic [63:0] lo, hi, elo, ehi, a, b;
      logic        ov, z, eov, bzf, bzd, dna, held;
      logic [2:0]  op;
      int          lat, elat;
      bit          s8;
      for (int i = 0; i < 60; i++) begin
         s8 = 1'($urandom_range(0, 1));
         op = 3'($urandom_range(0, 7));
         a  = pick_operand();
         b  = pick_operand();
         model(s8 ? 8 : 32, op, a, b, elo, ehi, eov, elat);
         issue(s8, op, a, b, lo, hi, ov, z, lat, bzf, bzd, dna, held);
         checks += 7;
         if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d exp=%0d", i, op, lat, elat); end
         if (lo !== elo) begin errors++; $display("FAIL rnd%0d_lo op=%0d got=%h exp=%h", i, op, lo, elo); end
         if (hi !== ehi) begin errors++; $display("FAIL rnd%0d_hi op=%0d got=%h exp=%h", i, op, hi, ehi); end
         if (ov !== eov) begin errors++; $display("FAIL rnd%0d_ov op=%0d got=%b exp=%b", i, op, ov, eov); end
         if (z !== (elo == 0)) begin errors++; $display("FAIL rnd%0d_zero got=%b exp=%b", i, z, elo == 0); end
         if (dna !== 1'b0) begin errors++; $display("FAIL rnd%0d_done_width got=%b exp=0", i, dna); end
         if (held !== 1'b1) begin errors++; $display("FAIL rnd%0d_hold got=%b exp=1", i, held); end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
